// File: rtl/perf_ctrl.sv
// perf_ctrl: performance-counter controller.
//   Seven CNT_W-bit event counters (cycles, IFU issue, I-cache access,
//   I-cache hit, LSU read, LSU write, LSU stall) with freeze, clear_all,
//   sticky overflow flags and a low/high read snapshot. All of it is reached
//   through a single-outstanding CSR request/response port.
//
// Ports:
//   clk, reset (async, active low)
//   ifu_valid, icache_valid, icache_start, icache_isHit,
//   lsu_ren, lsu_wen, lsu_isWaiting      - event tap inputs
//   csr_req_valid/csr_req_ready, csr_wen, csr_addr, csr_wdata - request
//   csr_resp_valid/csr_resp_ready, csr_rdata, csr_resp_err    - response
//   ovf_irq                               - only with PERF_CTRL_OVF_IRQ_EN
//
// Build option: define PERF_CTRL_OVF_IRQ_EN to add the ovf_irq output and
// CTRL bit2 (irq_en). Without it CTRL bit2 reads 0 and ignores writes.
//
// Register window, offset = csr_addr - CSR_BASE:
//   2i / 2i+1 : counter i low / high word
//   0x20 CTRL : bit0 freeze, bit1 clear_all (self-clearing), bit2 irq_en
//   0x21 STATUS: bits6:0 overflow flags, write-1-to-clear

module perf_ctrl #(
    parameter int          CNT_W    = 64,
    parameter logic [11:0] CSR_BASE = 12'hB00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_valid,
    input  logic        icache_valid,
    input  logic        icache_start,
    input  logic        icache_isHit,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic        lsu_isWaiting,
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic        csr_wen,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic        csr_resp_valid,
    input  logic        csr_resp_ready,
    output logic [31:0] csr_rdata,
`ifdef PERF_CTRL_OVF_IRQ_EN
    output logic        ovf_irq,
`endif
    output logic        csr_resp_err
);

    // state | meaning
    // IDLE  | ready for a request; access is performed on acceptance
    // RESP  | response registered and held until csr_resp_ready
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    localparam int HI_W = CNT_W - 32;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt    [7];
    logic [31:0]      cnt_hi [7];
    logic [6:0]       evt, wr_lo, wr_hi, inc, wrap;
    logic [6:0]       ovf, ovf_clr;
    logic             freeze, irq_en_q;
    logic [31:0]      shadow;
    logic [2:0]       shadow_idx;
    logic             shadow_vld;
    logic [11:0]      offset;
    logic [2:0]       idx;
    logic             is_cnt, is_ctrl, is_status;
    logic             accept, wr_acc, rd_acc, clear_all;
    logic [31:0]      rd_word;

    // Offset arithmetic wraps in 12 bits, so addresses below the base land
    // at large offsets and fall into the error case.
    assign offset    = csr_addr - CSR_BASE;
    assign idx       = offset[3:1];
    assign is_cnt    = offset < 12'd14;
    assign is_ctrl   = offset == 12'h020;
    assign is_status = offset == 12'h021;

    assign accept    = (state == IDLE) & csr_req_valid;
    assign wr_acc    = accept & csr_wen;
    assign rd_acc    = accept & ~csr_wen;
    assign clear_all = wr_acc & is_ctrl & csr_wdata[1];
    assign ovf_clr   = (wr_acc & is_status) ? csr_wdata[6:0] : 7'd0;

    assign evt = {lsu_isWaiting, lsu_wen, lsu_ren,
                  icache_valid & icache_start & icache_isHit,
                  icache_valid & icache_start, ifu_valid, 1'b1};

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            cnt_hi[i] = 32'(cnt[i] >> 32);
            wr_lo[i]  = wr_acc && (offset == 12'(2 * i));
            wr_hi[i]  = wr_acc && (offset == 12'(2 * i + 1));
            // A write or clear on this counter swallows the cycle's event.
            inc[i]    = evt[i] & ~freeze & ~wr_lo[i] & ~wr_hi[i] & ~clear_all;
            wrap[i]   = inc[i] & (&cnt[i]);
        end
    end

    always_comb begin
        rd_word = '0;
        if (is_cnt) begin
            if (!offset[0])
                rd_word = cnt[idx][31:0];
            else if (shadow_vld && (shadow_idx == idx))
                rd_word = shadow;
            else
                rd_word = cnt_hi[idx];
        end else if (is_ctrl) begin
            rd_word = {29'd0, irq_en_q, 1'b0, freeze};
        end else if (is_status) begin
            rd_word = {25'd0, ovf};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 7; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (clear_all)
                    cnt[i] <= '0;
                else if (wr_lo[i])
                    cnt[i][31:0] <= csr_wdata;
                else if (wr_hi[i])
                    cnt[i][CNT_W-1:32] <= csr_wdata[HI_W-1:0];
                else if (inc[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf        <= '0;
            freeze     <= 1'b0;
            shadow     <= '0;
            shadow_idx <= '0;
            shadow_vld <= 1'b0;
        end else begin
            // A wrap in the same cycle as a W1C of that bit keeps it set.
            ovf <= (ovf & ~ovf_clr) | wrap;
            if (wr_acc && is_ctrl)
                freeze <= csr_wdata[0];
            if (rd_acc && is_cnt && !offset[0]) begin
                shadow     <= cnt_hi[idx];
                shadow_idx <= idx;
                shadow_vld <= 1'b1;
            end
        end
    end

`ifdef PERF_CTRL_OVF_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            ovf_irq  <= 1'b0;
        end else begin
            if (wr_acc && is_ctrl)
                irq_en_q <= csr_wdata[2];
            ovf_irq <= irq_en_q & (|ovf);
        end
    end
`else
    assign irq_en_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        csr_req_ready  = 1'b0;
        csr_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                csr_req_ready = 1'b1;
                if (csr_req_valid)
                    state_nxt = RESP;
            end
            RESP: begin
                csr_resp_valid = 1'b1;
                if (csr_resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csr_rdata    <= '0;
            csr_resp_err <= 1'b0;
        end else if (accept) begin
            csr_rdata    <= csr_wen ? 32'd0 : rd_word;
            csr_resp_err <= ~(is_cnt | is_ctrl | is_status);
        end
    end

endmodule
